// File: rtl/sd_menu_pager.sv
// Paged file-selection menu for the SD loader: joypad navigation with debounce
// and auto-repeat, page re-list requests, and cursor glyph painting into the overlay.
module sd_menu_pager #(
    parameter int FREQ         = 27_000_000,
    parameter int ROWS         = 20,
    parameter int FILE_W       = 10,
    parameter int X0           = 8,
    parameter int Y0           = 40,
    parameter int FG           = 55,
    parameter int BG           = 13,
    parameter int DEB_MS       = 50,
    parameter int RPT_DELAY_MS = 400,
    parameter int RPT_MS       = 100
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              list_done,
    input  logic [FILE_W-1:0] file_count,
    input  logic [7:0]        nes_btn,
    output logic [FILE_W-1:0] page_base,
    output logic              page_req,
    output logic [FILE_W-1:0] sel_file,
    output logic              sel_valid,
    output logic              overlay,
    output logic [5:0]        color,
    output logic [7:0]        scanline,
    output logic [7:0]        cycle
);

    // state  | meaning
    // S_IDLE | menu inactive, waiting for enable rising edge
    // S_WAIT | page re-list requested, waiting for list_done
    // S_NAV  | cursor shown, pad events processed
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_NAV} state_t;
    typedef enum logic [2:0] {K_NONE, K_U, K_D, K_L, K_R} key_t;

    localparam int DEB_CYC = FREQ / 1000 * DEB_MS;
    localparam int DLY_CYC = FREQ / 1000 * RPT_DELAY_MS;
    localparam int PER_CYC = FREQ / 1000 * RPT_MS;
    localparam int LW      = $clog2(DEB_CYC + 1);
    localparam int RW      = $clog2(((DLY_CYC > PER_CYC) ? DLY_CYC : PER_CYC) + 1);
    localparam int FW1     = FILE_W + 1;
    localparam logic [FILE_W:0]   ROWS_X  = FW1'(ROWS);
    localparam logic [FILE_W-1:0] ROWS_F  = ROWS_X[FILE_W-1:0];
    localparam logic [4:0]        ROWS_M1 = 5'(ROWS - 1);

    state_t            state;
    key_t              key, key_q;
    logic [4:0]        btn_m, btn_s;
    logic              a_q, a_edge;
    logic              pend, fire_new, fire_rpt, dir_ev;
    logic [LW-1:0]     lock_cnt;
    logic [RW-1:0]     rpt_cnt;
    logic              enable_q;
    logic [FILE_W-1:0] count;
    logic [4:0]        row, last_nav, last_new;
    logic [FILE_W:0]   pb_up;
    logic              can_next, can_prev;
    logic [4:0]        r_cnt;
    logic [5:0]        dot;
    logic              unused_btn;

    assign unused_btn = ^nes_btn[3:1];

    function automatic logic [4:0] last_of(input logic [FILE_W-1:0] rem);
        if (rem == '0)
            return 5'd0;
        else if (rem >= ROWS_F)
            return ROWS_M1;
        else
            return 5'(rem - 1'b1);
    endfunction

    function automatic logic glyph_px(input logic [5:0] d);
        logic [7:0] line;
        case (d[5:3])
            3'd1, 3'd7: line = 8'h03;
            3'd2, 3'd6: line = 8'h0F;
            3'd3, 3'd5: line = 8'h3F;
            3'd4:       line = 8'hFF;
            default:    line = 8'h00;
        endcase
        return line[d[2:0]];
    endfunction

    // Synchronised pad bits: {R,L,D,U,A}
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_m <= '0;
            btn_s <= '0;
            a_q   <= 1'b0;
        end else begin
            btn_m <= {nes_btn[7:4], nes_btn[0]};
            btn_s <= btn_m;
            a_q   <= btn_s[0];
        end
    end

    assign a_edge = btn_s[0] && !a_q;

    always_comb begin
        key = K_NONE;
        if (btn_s[1])
            key = K_U;
        else if (btn_s[2])
            key = K_D;
        else if (btn_s[3])
            key = K_L;
        else if (btn_s[4])
            key = K_R;
    end

    // A fresh press waits (pend) until the lockout has drained, then fires once.
    assign fire_new = (key != K_NONE) && ((key != key_q) || pend) && (lock_cnt == '0);
    assign fire_rpt = (key != K_NONE) && (key == key_q) && !pend && (rpt_cnt == '0);
    assign dir_ev   = fire_new || fire_rpt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q    <= K_NONE;
            pend     <= 1'b0;
            lock_cnt <= '0;
            rpt_cnt  <= '0;
        end else begin
            key_q <= key;
            if (key == K_NONE || fire_new)
                pend <= 1'b0;
            else if (key != key_q)
                pend <= 1'b1;

            if (dir_ev)
                lock_cnt <= LW'(DEB_CYC - 1);
            else if (lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;

            if (fire_new)
                rpt_cnt <= RW'(DLY_CYC - 1);
            else if (fire_rpt)
                rpt_cnt <= RW'(PER_CYC - 1);
            else if (rpt_cnt != '0)
                rpt_cnt <= rpt_cnt - 1'b1;
        end
    end

    assign last_nav = last_of(count - page_base);
    assign last_new = last_of(file_count - page_base);
    assign pb_up    = {1'b0, page_base} + ROWS_X;
    assign can_next = pb_up < {1'b0, count};
    assign can_prev = page_base != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            enable_q  <= 1'b0;
            page_base <= '0;
            page_req  <= 1'b0;
            sel_file  <= '0;
            sel_valid <= 1'b0;
            count     <= '0;
            row       <= '0;
        end else begin
            page_req  <= 1'b0;
            sel_valid <= 1'b0;
            enable_q  <= enable;
            if (!enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!enable_q) begin
                            page_base <= '0;
                            row       <= '0;
                            page_req  <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (list_done) begin
                            count <= file_count;
                            if (file_count == '0)
                                row <= '0;
                            else if (row > last_new)
                                row <= last_new;
                            state <= S_NAV;
                        end
                    end
                    S_NAV: begin
                        if (a_edge && count != '0) begin
                            sel_file  <= page_base + FILE_W'(row);
                            sel_valid <= 1'b1;
                            state     <= S_IDLE;
                        end else if (dir_ev) begin
                            case (key)
                                K_U: begin
                                    if (row != '0) begin
                                        row <= row - 1'b1;
                                    end else if (can_prev) begin
                                        page_base <= page_base - ROWS_F;
                                        row       <= ROWS_M1;
                                        page_req  <= 1'b1;
                                        state     <= S_WAIT;
                                    end
                                end
                                K_D: begin
                                    if (row < last_nav) begin
                                        row <= row + 1'b1;
                                    end else if (can_next) begin
                                        page_base <= pb_up[FILE_W-1:0];
                                        row       <= '0;
                                        page_req  <= 1'b1;
                                        state     <= S_WAIT;
                                    end
                                end
                                K_L: begin
                                    if (can_prev) begin
                                        page_base <= page_base - ROWS_F;
                                        page_req  <= 1'b1;
                                        state     <= S_WAIT;
                                    end
                                end
                                K_R: begin
                                    if (can_next) begin
                                        page_base <= pb_up[FILE_W-1:0];
                                        page_req  <= 1'b1;
                                        state     <= S_WAIT;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Every sweep repaints all rows, so the old cursor position is erased for free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            dot      <= '0;
            overlay  <= 1'b0;
            color    <= '0;
            scanline <= '0;
            cycle    <= '0;
        end else begin
            if (dot == 6'd63) begin
                dot   <= '0;
                r_cnt <= (r_cnt == ROWS_M1) ? 5'd0 : r_cnt + 1'b1;
            end else begin
                dot <= dot + 1'b1;
            end

            if (state == S_NAV) begin
                overlay  <= 1'b1;
                scanline <= 8'(Y0) + {r_cnt, 3'b000} + {5'b0, dot[5:3]};
                cycle    <= 8'(X0) + {5'b0, dot[2:0]};
                color    <= (r_cnt == row && count != '0 && glyph_px(dot)) ? 6'(FG) : 6'(BG);
            end else begin
                overlay  <= 1'b0;
                scanline <= '0;
                cycle    <= '0;
                color    <= '0;
            end
        end
    end

endmodule
